// File: rtl/mod12_sched_pkg.sv
// Shared types and constants for the mod-12 counter command scheduler.
package mod12_sched_pkg;

  localparam int unsigned MOD       = 12;
  localparam int unsigned MAX_COUNT = 11;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned LEN_W     = 4;
  localparam int unsigned NREQ      = 2;

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_LOAD = 2'b01,
    OP_UP   = 2'b10,
    OP_DOWN = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_LOAD = 3'd2,
    ST_RUN  = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  // Command latched at acceptance; len doubles as the remaining RUN step count.
  typedef struct packed {
    op_e              op;
    logic             id;
    logic [CNT_W-1:0] data;
    logic [LEN_W-1:0] len;
  } cmd_t;

  // One counter step with wrap 11->0 (up) and 0->11 (down).
  function automatic logic [CNT_W-1:0] mod12_step(input logic [CNT_W-1:0] c,
                                                  input logic             up);
    if (up) begin
      return (c >= CNT_W'(MAX_COUNT)) ? '0 : c + CNT_W'(1);
    end
    return (c == '0) ? CNT_W'(MOD - 1) : c - CNT_W'(1);
  endfunction

endpackage

// File: rtl/mod12_rr_arb2.sv
// Two-way round-robin arbiter; priority flips to the other requester on accept.
module mod12_rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  input  logic       accept_id,
  output logic [1:0] grant_c
);

  logic prio;

  // Priority pointer: requester 0 first after reset, then the loser of the last grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prio <= 1'b0;
    end else if (accept) begin
      prio <= ~accept_id;
    end
  end

  // One-hot grant: the priority requester if it asks, otherwise the other one.
  always_comb begin
    grant_c = 2'b00;
    if (!prio) begin
      if (req[0])      grant_c = 2'b01;
      else if (req[1]) grant_c = 2'b10;
    end else begin
      if (req[1])      grant_c = 2'b10;
      else if (req[0]) grant_c = 2'b01;
    end
  end

endmodule

// File: rtl/mod12_cnt_sched.sv
// Schedules READ/LOAD/UP/DOWN commands from two requesters onto an external
// mod-12 counter and returns one response per command.
module mod12_cnt_sched
  import mod12_sched_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0][1:0]        req_op,
  input  logic [NREQ-1:0][CNT_W-1:0]  req_data,
  input  logic [NREQ-1:0][LEN_W-1:0]  req_len,
  output logic                        cnt_reset,
  output logic                        cnt_load,
  output logic                        cnt_mode,
  output logic [CNT_W-1:0]            cnt_data_in,
  input  logic [CNT_W-1:0]            cnt_count,
  output logic                        rsp_valid,
  output logic                        rsp_id,
  output logic [CNT_W-1:0]            rsp_count,
  output logic                        rsp_err
);

  state_e           state;
  cmd_t             cmd;
  cmd_t             acc_cmd_c;
  logic [NREQ-1:0]  grant_c;
  logic             accept_c;
  logic             accept_id_c;
  logic [CNT_W-1:0] step_c;

  assign accept_c    = (state == ST_IDLE) && (|(req_valid & req_ready));
  assign accept_id_c = req_ready[1];
  assign step_c      = mod12_step(cnt_count, cmd.op == OP_UP);

  mod12_rr_arb2 u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (req_valid),
    .accept    (accept_c),
    .accept_id (accept_id_c),
    .grant_c   (grant_c)
  );

  // Command fields of the requester being accepted this cycle.
  always_comb begin
    acc_cmd_c      = '0;
    acc_cmd_c.op   = op_e'(req_op[accept_id_c]);
    acc_cmd_c.id   = accept_id_c;
    acc_cmd_c.data = req_data[accept_id_c];
    acc_cmd_c.len  = req_len[accept_id_c];
  end

  // Scheduler FSM; all outputs are registered and the counter is held outside RUN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_INIT;
      cmd         <= '0;
      req_ready   <= '0;
      cnt_reset   <= 1'b1;
      cnt_load    <= 1'b0;
      cnt_mode    <= 1'b0;
      cnt_data_in <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_count   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          // Counter is being cleared on this edge, so hold it at zero afterwards.
          state       <= ST_IDLE;
          cnt_reset   <= 1'b0;
          cnt_load    <= 1'b1;
          cnt_data_in <= '0;
          req_ready   <= grant_c;
        end

        ST_IDLE: begin
          if (accept_c) begin
            req_ready <= '0;
            cmd       <= acc_cmd_c;
            case (acc_cmd_c.op)
              OP_LOAD: begin
                if (acc_cmd_c.data <= CNT_W'(MAX_COUNT)) begin
                  state       <= ST_LOAD;
                  cnt_data_in <= acc_cmd_c.data;
                end else begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_id    <= accept_id_c;
                  rsp_count <= cnt_count;
                  rsp_err   <= 1'b1;
                end
              end
              OP_UP, OP_DOWN: begin
                if (acc_cmd_c.len != '0) begin
                  state    <= ST_RUN;
                  cnt_load <= 1'b0;
                  cnt_mode <= (acc_cmd_c.op == OP_UP);
                end else begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_id    <= accept_id_c;
                  rsp_count <= cnt_count;
                  rsp_err   <= 1'b0;
                end
              end
              default: begin
                state     <= ST_RESP;
                rsp_valid <= 1'b1;
                rsp_id    <= accept_id_c;
                rsp_count <= cnt_count;
                rsp_err   <= 1'b0;
              end
            endcase
          end else begin
            req_ready <= grant_c;
          end
        end

        ST_LOAD: begin
          // Counter takes cmd.data on this edge; keep presenting it as the hold value.
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_id    <= cmd.id;
          rsp_count <= cmd.data;
          rsp_err   <= 1'b0;
        end

        ST_RUN: begin
          if (cmd.len == LEN_W'(1)) begin
            // Last step happens on this edge; freeze the counter at the stepped value.
            state       <= ST_RESP;
            cnt_load    <= 1'b1;
            cnt_data_in <= step_c;
            rsp_valid   <= 1'b1;
            rsp_id      <= cmd.id;
            rsp_count   <= step_c;
            rsp_err     <= 1'b0;
          end else begin
            cmd.len <= cmd.len - LEN_W'(1);
          end
        end

        ST_RESP: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= grant_c;
        end

        default: begin
          state     <= ST_INIT;
          req_ready <= '0;
          cnt_reset <= 1'b1;
          cnt_load  <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mod12_cnt_sched.md
MOD12_CNT_SCHED -- requirements
Module: mod12_cnt_sched

Interface
REQ-001 The block SHALL have exactly one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 clock  in  1  single clock; all state changes on posedge clock.
REQ-003 reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-004 req_valid  in  2  per-requester command valid (index 0, 1).
REQ-005 req_ready  out  2  per-requester accept strobe; at most one bit high per cycle.
REQ-006 req_op  in  2x2  per-requester op: 00 READ, 01 LOAD, 10 UP, 11 DOWN.
REQ-007 req_data  in  2x4  per-requester LOAD value.
REQ-008 req_len  in  2x4  per-requester UP/DOWN step count, 0..15.
REQ-009 cnt_reset  out  1  counter synchronous reset, active-high, clears count to 0.
REQ-010 cnt_load  out  1  counter load strobe.
REQ-011 cnt_mode  out  1  counter direction: 1 up, 0 down.
REQ-012 cnt_data_in  out  4  counter load value.
REQ-013 cnt_count  in  4  counter registered output, 0..11.
REQ-014 rsp_valid  out  1  one-cycle response strobe.
REQ-015 rsp_id  out  1  requester index of the response.
REQ-016 rsp_count  out  4  cnt_count sampled in the RESP cycle.
REQ-017 rsp_err  out  1  the command was rejected.

Function
REQ-018 States SHALL be INIT, IDLE, LOAD, RUN, RESP; every output SHALL be registered or decoded from state plus registers only.
REQ-019 INIT SHALL drive cnt_reset=1 and cnt_load=0 for one cycle, then go to IDLE.
REQ-020 IDLE, RESP and INIT-exit SHALL hold the counter by driving cnt_load=1 with cnt_data_in=cnt_count; the counter SHALL never free-run outside RUN.
REQ-021 In IDLE with any req_valid high, the block SHALL raise req_ready for exactly one granted requester; the handshake is req_valid&req_ready at the clock edge.
REQ-022 Arbitration SHALL be 2-way round-robin; after reset, requester 0 has priority, and after each grant the other requester has priority.
REQ-023 req_ready SHALL be 0 in every state except IDLE.
REQ-024 Requesters SHALL hold req_valid, op, data and len stable until accepted; the block SHALL latch op, id, data and len at acceptance.
REQ-025 READ: accept -> RESP on the next cycle (latency 1).
REQ-026 LOAD with data<=11: one LOAD cycle with cnt_load=1 and cnt_data_in=data, then RESP (latency 2, rsp_count=data).
REQ-027 LOAD with data>11: go directly to RESP with rsp_err=1; counter unchanged.
REQ-028 UP/DOWN with len=N>0: N RUN cycles with cnt_load=0 and cnt_mode=dir, then RESP (latency N+1).
REQ-029 UP/DOWN with len=0: treat as READ.
REQ-030 The counter SHALL wrap up 11->0 and down 0->11; rsp_count SHALL equal (start±N) mod 12.
REQ-031 RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE; a new grant is possible in the cycle after RESP.
REQ-032 When one requester holds valid continuously and the other is idle, the active requester SHALL be served every (latency+1) cycles without starvation.

Reset
REQ-033 While reset=0: state=INIT, req_ready=0, rsp_valid=0, rsp_id=0, rsp_count=0, rsp_err=0, cnt_load=0, cnt_mode=0, cnt_data_in=0, cnt_reset=1, and round-robin priority=requester 0.
REQ-034 Reset asserted mid-operation SHALL abort the command with no response; the aborted command is lost.

Structure
REQ-035 Shared package mod12_sched_pkg SHALL hold the op enum, state enum, MOD=12 and MAX_COUNT=11.
REQ-036 Round-robin arbitration SHALL be a sub-module, mod12_rr_arb2 (2-bit request in, one-hot grant out, priority pointer updated on accept).

Verification
REQ-037 Release reset -> cnt_reset=1 for one cycle; READ from requester 0 then returns rsp_count=0 at latency 1.
REQ-038 LOAD 9 from requester 1 -> rsp_valid 2 cycles after accept with rsp_id=1, rsp_count=9, rsp_err=0; LOAD 13 -> rsp_err=1 and count stays 9.
REQ-039 LOAD 10 then UP len=3 -> RESP at accept+4 with rsp_count=1 (wrap); DOWN len=2 from 1 -> rsp_count=11.
REQ-040 Both requesters valid continuously with READ -> grants alternate 0,1,0,1; req_ready is never high on both bits at once.
REQ-041 Reset pulled low during RUN of UP len=8 -> no rsp_valid; after release, READ returns 0.
